// File: rtl/rob_tag_alloc.sv
// Reorder buffer: hands out tags at the tail, collects writebacks, retires in order from the head.
// Optional second writeback port enabled by defining ROB_DUAL_WB_EN.
module rob_tag_alloc #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_req,
  input  logic [4:0]        alloc_dest,
  output logic              alloc_ready,
  output logic [4:0]        alloc_tag,
  input  logic              wb_valid,
  input  logic [4:0]        wb_tag,
  input  logic [DATA_W-1:0] wb_data,
`ifdef ROB_DUAL_WB_EN
  input  logic              wb2_valid,
  input  logic [4:0]        wb2_tag,
  input  logic [DATA_W-1:0] wb2_data,
`endif
  output logic              commit_valid,
  output logic [4:0]        commit_tag,
  output logic [4:0]        commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [5:0]        count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = 6;

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  done;
  logic [TAG_W-1:0]  dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              full;
  logic              do_alloc;
  logic              do_retire;
  logic [IDX_W-1:0]  wb_idx;
  logic              wb_hit;
`ifdef ROB_DUAL_WB_EN
  logic [IDX_W-1:0]  wb2_idx;
  logic              wb2_hit;
`endif

  // Handshake and event decode, all from registered state
  always_comb begin
    full        = (count == CNT_W'(DEPTH));
    alloc_ready = !full;
    alloc_tag   = TAG_W'(tail);
    do_alloc    = alloc_req && !full;
    do_retire   = valid[head] && done[head];
    wb_idx      = wb_tag[IDX_W-1:0];
    // Out-of-range tags and invalid entries drop the writeback; the retiring head is not re-marked
    wb_hit      = wb_valid && ({1'b0, wb_tag} < CNT_W'(DEPTH)) && valid[wb_idx]
                  && !(do_retire && (wb_idx == head));
`ifdef ROB_DUAL_WB_EN
    wb2_idx     = wb2_tag[IDX_W-1:0];
    wb2_hit     = wb2_valid && ({1'b0, wb2_tag} < CNT_W'(DEPTH)) && valid[wb2_idx]
                  && !(do_retire && (wb2_idx == head));
`endif
  end

  // Control state: pointers, occupancy, per-entry flags and the commit port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid        <= '0;
      done         <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_dest  <= '0;
      commit_data  <= '0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid        <= '0;
      done         <= '0;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= do_retire;
      if (do_retire) begin
        commit_tag   <= TAG_W'(head);
        commit_dest  <= dest_mem[head];
        commit_data  <= data_mem[head];
        valid[head]  <= 1'b0;
        done[head]   <= 1'b0;
        head         <= head + IDX_W'(1);
      end
`ifdef ROB_DUAL_WB_EN
      if (wb2_hit) done[wb2_idx] <= 1'b1;
`endif
      if (wb_hit) done[wb_idx] <= 1'b1;
      if (do_alloc) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= tail + IDX_W'(1);
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(do_retire);
    end
  end

  // Payload storage; port 1 is written last so it wins a same-tag collision
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (do_alloc) dest_mem[tail] <= alloc_dest;
`ifdef ROB_DUAL_WB_EN
      if (wb2_hit) data_mem[wb2_idx] <= wb2_data;
`endif
      if (wb_hit) data_mem[wb_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_rob_tag_alloc.sv
// Directed self-checking bench for rob_tag_alloc (DEPTH=16, DATA_W=32).
// Define ROB_DUAL_WB_EN to also exercise the second writeback port.
module tb_rob_tag_alloc;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alloc_req;
  logic [4:0]  alloc_dest;
  logic        alloc_ready;
  logic [4:0]  alloc_tag;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
`ifdef ROB_DUAL_WB_EN
  logic        wb2_valid;
  logic [4:0]  wb2_tag;
  logic [31:0] wb2_data;
`endif
  logic        commit_valid;
  logic [4:0]  commit_tag;
  logic [4:0]  commit_dest;
  logic [31:0] commit_data;
  logic [5:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  rob_tag_alloc #(.DEPTH(16), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_req    (alloc_req),
    .alloc_dest   (alloc_dest),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data),
`ifdef ROB_DUAL_WB_EN
    .wb2_valid    (wb2_valid),
    .wb2_tag      (wb2_tag),
    .wb2_data     (wb2_data),
`endif
    .commit_valid (commit_valid),
    .commit_tag   (commit_tag),
    .commit_dest  (commit_dest),
    .commit_data  (commit_data),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (count !== 6'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", alloc_ready); end
    n_cmp++; if (alloc_tag !== 5'd0) begin n_err++; $display("FAIL reset_tag got %0d want 0", alloc_tag); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL reset_cv got %0b want 0", commit_valid); end
    n_cmp++; if ({commit_tag, commit_dest, commit_data} !== 42'd0) begin
      n_err++; $display("FAIL reset_commit got %0h/%0h/%0h want 0/0/0", commit_tag, commit_dest, commit_data);
    end
  endtask

  task automatic test_alloc();
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1; alloc_dest = 5'(5 + i);
      n_cmp++; if (alloc_tag !== 5'(i)) begin n_err++; $display("FAIL alloc_tag[%0d] got %0d want %0d", i, alloc_tag, i); end
      step();
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL alloc_cv[%0d] got %0b want 0", i, commit_valid); end
    end
    alloc_req = 1'b0;
    n_cmp++; if (count !== 6'd3) begin n_err++; $display("FAIL alloc_count got %0d want 3", count); end
    n_cmp++; if (alloc_tag !== 5'd3) begin n_err++; $display("FAIL alloc_tag_after got %0d want 3", alloc_tag); end
  endtask

  task automatic test_ooo_wb();
    wb_valid = 1'b1; wb_tag = 5'd1; wb_data = 32'hAA;
    step();
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ooo_cv_early got %0b want 0", commit_valid); end
    wb_tag = 5'd0; wb_data = 32'h55;
    step();
    wb_valid = 1'b0;
    n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ooo_cv_same got %0b want 0", commit_valid); end
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_dest, commit_data} !== {1'b1, 5'd0, 5'd5, 32'h55}) begin
      n_err++; $display("FAIL ooo_first got v%0b t%0d d%0d %0h want v1 t0 d5 55", commit_valid, commit_tag, commit_dest, commit_data);
    end
    n_cmp++; if (count !== 6'd2) begin n_err++; $display("FAIL ooo_count1 got %0d want 2", count); end
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_dest, commit_data} !== {1'b1, 5'd1, 5'd6, 32'hAA}) begin
      n_err++; $display("FAIL ooo_second got v%0b t%0d d%0d %0h want v1 t1 d6 aa", commit_valid, commit_tag, commit_dest, commit_data);
    end
    step();
    n_cmp++; if ({commit_valid, commit_data} !== {1'b0, 32'hAA}) begin
      n_err++; $display("FAIL ooo_hold got v%0b %0h want v0 aa", commit_valid, commit_data);
    end
    n_cmp++; if (count !== 6'd1) begin n_err++; $display("FAIL ooo_count2 got %0d want 1", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1; alloc_dest = 5'(8 + i);
      step();
    end
    n_cmp++; if (count !== 6'd5) begin n_err++; $display("FAIL flush_pre_count got %0d want 5", count); end
    wb_valid = 1'b1; wb_tag = 5'd2; wb_data = 32'h77; flush = 1'b1;
    step();
    flush = 1'b0; alloc_req = 1'b0; wb_valid = 1'b0;
    n_cmp++; if ({count, alloc_tag, alloc_ready, commit_valid} !== {6'd0, 5'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL flush_state got c%0d t%0d r%0b v%0b want c0 t0 r1 v0", count, alloc_tag, alloc_ready, commit_valid);
    end
    step();
    n_cmp++; if ({commit_valid, count} !== {1'b0, 6'd0}) begin
      n_err++; $display("FAIL flush_after got v%0b c%0d want v0 c0", commit_valid, count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      alloc_req = 1'b1; alloc_dest = 5'(i);
      step();
    end
    n_cmp++; if ({count, alloc_ready, alloc_tag} !== {6'd16, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL full_state got c%0d r%0b t%0d want c16 r0 t0", count, alloc_ready, alloc_tag);
    end
    alloc_dest = 5'd31; wb_valid = 1'b1; wb_tag = 5'd0; wb_data = 32'h100;
    step();
    wb_valid = 1'b0;
    n_cmp++; if ({count, alloc_ready, commit_valid} !== {6'd16, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL full_ignore got c%0d r%0b v%0b want c16 r0 v0", count, alloc_ready, commit_valid);
    end
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_dest, commit_data} !== {1'b1, 5'd0, 5'd0, 32'h100}) begin
      n_err++; $display("FAIL full_retire got v%0b t%0d d%0d %0h want v1 t0 d0 100", commit_valid, commit_tag, commit_dest, commit_data);
    end
    n_cmp++; if ({count, alloc_ready, alloc_tag} !== {6'd15, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL full_space got c%0d r%0b t%0d want c15 r1 t0", count, alloc_ready, alloc_tag);
    end
    step();
    alloc_req = 1'b0;
    n_cmp++; if ({count, alloc_ready, alloc_tag, commit_valid} !== {6'd16, 1'b0, 5'd1, 1'b0}) begin
      n_err++; $display("FAIL full_wrap got c%0d r%0b t%0d v%0b want c16 r0 t1 v0", count, alloc_ready, alloc_tag, commit_valid);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_unalloc_wb();
    wb_valid = 1'b1; wb_tag = 5'd9; wb_data = 32'hFFFF;
    step();
    wb_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alloc_req = 1'b1; alloc_dest = 5'(20 + i);
      step();
    end
    alloc_req = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wb_valid = 1'b1; wb_tag = 5'(k); wb_data = 32'h300 + 32'(k);
      step();
      if (k >= 1) begin
        n_cmp++; if ({commit_valid, commit_tag} !== {1'b1, 5'(k - 1)}) begin
          n_err++; $display("FAIL seq_commit[%0d] got v%0b t%0d want v1 t%0d", k, commit_valid, commit_tag, k - 1);
        end
      end
    end
    wb_valid = 1'b0;
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_data} !== {1'b1, 5'd8, 32'h308}) begin
      n_err++; $display("FAIL seq_last got v%0b t%0d %0h want v1 t8 308", commit_valid, commit_tag, commit_data);
    end
    step(); step();
    n_cmp++; if ({commit_valid, count} !== {1'b0, 6'd1}) begin
      n_err++; $display("FAIL unalloc_wait got v%0b c%0d want v0 c1", commit_valid, count);
    end
    wb_valid = 1'b1; wb_tag = 5'd9; wb_data = 32'h1234;
    step();
    wb_valid = 1'b0;
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_dest, commit_data, count} !== {1'b1, 5'd9, 5'd29, 32'h1234, 6'd0}) begin
      n_err++; $display("FAIL unalloc_own got v%0b t%0d d%0d %0h c%0d want v1 t9 d29 1234 c0",
                        commit_valid, commit_tag, commit_dest, commit_data, count);
    end
  endtask

  task automatic test_wb_tail();
    alloc_req = 1'b1; alloc_dest = 5'd3; wb_valid = 1'b1; wb_tag = 5'd10; wb_data = 32'hBEEF;
    step();
    alloc_req = 1'b0; wb_valid = 1'b0;
    step(); step();
    n_cmp++; if ({commit_valid, count} !== {1'b0, 6'd1}) begin
      n_err++; $display("FAIL tail_drop got v%0b c%0d want v0 c1", commit_valid, count);
    end
    wb_valid = 1'b1; wb_data = 32'hCAFE;
    step();
    wb_valid = 1'b0;
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_dest, commit_data} !== {1'b1, 5'd10, 5'd3, 32'hCAFE}) begin
      n_err++; $display("FAIL tail_commit got v%0b t%0d d%0d %0h want v1 t10 d3 cafe", commit_valid, commit_tag, commit_dest, commit_data);
    end
  endtask

  task automatic test_async_reset();
    alloc_req = 1'b1; alloc_dest = 5'd4;
    step();
    alloc_req = 1'b0; wb_valid = 1'b1; wb_tag = 5'd11; wb_data = 32'h9;
    step();
    wb_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if ({count, alloc_tag, commit_valid, commit_tag} !== {6'd0, 5'd0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL arst_now got c%0d t%0d v%0b ct%0d want c0 t0 v0 ct0", count, alloc_tag, commit_valid, commit_tag);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_cmp++; if ({commit_valid, count} !== {1'b0, 6'd0}) begin
      n_err++; $display("FAIL arst_after got v%0b c%0d want v0 c0", commit_valid, count);
    end
  endtask

`ifdef ROB_DUAL_WB_EN
  task automatic test_dual_wb();
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1; alloc_dest = 5'(1 + i);
      step();
    end
    alloc_req = 1'b0;
    wb_valid = 1'b1; wb_tag = 5'd2; wb_data = 32'h11;
    wb2_valid = 1'b1; wb2_tag = 5'd3; wb2_data = 32'h22;
    step();
    wb_tag = 5'd0; wb_data = 32'h1; wb2_tag = 5'd0; wb2_data = 32'h2;
    step();
    wb2_valid = 1'b0; wb_tag = 5'd1; wb_data = 32'h5;
    step();
    wb_valid = 1'b0;
    n_cmp++; if ({commit_valid, commit_tag, commit_data} !== {1'b1, 5'd0, 32'h1}) begin
      n_err++; $display("FAIL dual_same got v%0b t%0d %0h want v1 t0 1", commit_valid, commit_tag, commit_data);
    end
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_data} !== {1'b1, 5'd1, 32'h5}) begin
      n_err++; $display("FAIL dual_t1 got v%0b t%0d %0h want v1 t1 5", commit_valid, commit_tag, commit_data);
    end
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_data} !== {1'b1, 5'd2, 32'h11}) begin
      n_err++; $display("FAIL dual_t2 got v%0b t%0d %0h want v1 t2 11", commit_valid, commit_tag, commit_data);
    end
    step();
    n_cmp++; if ({commit_valid, commit_tag, commit_dest, commit_data} !== {1'b1, 5'd3, 5'd4, 32'h22}) begin
      n_err++; $display("FAIL dual_t3 got v%0b t%0d d%0d %0h want v1 t3 d4 22", commit_valid, commit_tag, commit_dest, commit_data);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; flush = 1'b0; alloc_req = 1'b0; alloc_dest = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
`ifdef ROB_DUAL_WB_EN
    wb2_valid = 1'b0; wb2_tag = '0; wb2_data = '0;
`endif
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_alloc();
    test_ooo_wb();
    test_flush();
    test_full();
    test_unalloc_wb();
    test_wb_tail();
    test_async_reset();
`ifdef ROB_DUAL_WB_EN
    test_dual_wb();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rob_tag_alloc.md
Name: rob_tag_alloc

Overview:
- Reorder buffer for the out-of-order core. It is the producer/retire side of the register alias table handshake.
- Issues ROB tags to rename, collects execution writebacks, and retires entries in program order.
- On retire it presents the freed tag and destination register for RAT release and register-file write.
- Sits between rename/dispatch (allocation), the execution units (writeback) and the architectural register file (commit).

Parameters:
- DEPTH, 16, number of ROB entries. Power of two, 2..32; tags are index values 0..DEPTH-1 carried on 5-bit buses.
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  squash all entries (mispredict/exception)
- alloc_req  in  1  rename requests an entry this cycle
- alloc_dest  in  5  architectural destination register of the new entry
- alloc_ready  out  1  ROB not full; combinational from registered count
- alloc_tag  out  5  tag granted, equal to the tail index (valid when alloc_ready)
- wb_valid  in  1  execution result valid
- wb_tag  in  5  tag of the completing entry
- wb_data  in  DATA_W  result
- commit_valid  out  1  one entry retired (registered)
- commit_tag  out  5  retired tag (drives RAT free/tag_done)
- commit_dest  out  5  retired destination register
- commit_data  out  DATA_W  retired result
- count  out  6  occupied entries, 0..DEPTH

Behaviour:
- Reset (rst=0, async): head=tail=0, count=0, all entry valid/done bits 0, commit_valid=0, commit_tag/dest/data=0, alloc_ready=1, alloc_tag=0.
- Storage: circular buffer. head and tail are log2(DEPTH)-bit indices that wrap modulo DEPTH. full is count==DEPTH; empty is count==0.
- Each entry holds valid, done, dest[4:0] and data[DATA_W-1:0].
- Allocate: on a clk edge with alloc_req && alloc_ready:
  - entry[tail] gets valid=1, done=0, dest=alloc_dest;
  - tail increments and wraps DEPTH-1 -> 0.
  - alloc_req while full is ignored, with no state change; the requester holds the request.
- Writeback: on a clk edge with wb_valid, entry[wb_tag] gets done=1 and data=wb_data, only if entry[wb_tag].valid=1. A writeback to an invalid entry is dropped silently.
- Retire: on a clk edge where entry[head].valid && entry[head].done:
  - next cycle commit_valid=1, with commit_tag=head and commit_dest/commit_data taken from the entry;
  - entry[head].valid is cleared and head increments.
  - At most one retire per cycle; otherwise commit_valid=0 next cycle and the commit data outputs hold their last values.
- Latency:
  - writeback at edge N to the head entry -> commit_valid high after edge N+1;
  - allocation at edge N -> alloc_tag advances after edge N.
- Simultaneous events:
  - Allocate and retire in the same cycle: count unchanged.
  - Full and retiring: alloc_ready is still 0 that cycle, because full uses the registered count; space appears next cycle.
  - Writeback to the tail being allocated that same cycle: the entry is not yet valid, so the writeback is dropped.
  - Writeback to head in the same cycle head is evaluated: done is not yet visible, so the retire happens the following cycle.
- Flush (synchronous, highest priority): clears all valid/done bits, head=tail=0, count=0, commit_valid=0 next cycle. Any alloc/wb/retire in that cycle is discarded.
- Async reset mid-operation: immediate return to reset state; no partial commit is emitted.
- count: +1 on allocate, -1 on retire, never exceeds DEPTH or underflows.

Optional Feature:
- Macro ROB_DUAL_WB_EN.
- Defined: adds ports wb2_valid (in, 1), wb2_tag (in, 5) and wb2_data (in, DATA_W), giving a second writeback port with the same rules as port 1.
  - Both ports targeting the same tag in one cycle: port 1 data is written.
  - Different tags: both entries are marked done.
- Undefined: wb2_* ports are absent; single writeback port only.

Test Plan:
- Reset then alloc_req=1 for 3 cycles, dest 5,6,7 -> alloc_tag 0,1,2; count=3; commit_valid stays 0.
- Writeback tag1=0xAA, then tag0=0x55 -> after tag0's edge+1: commit_valid with tag0/dest5/0x55; next cycle tag1/dest6/0xAA (in order despite out-of-order completion).
- Fill DEPTH=16 entries -> alloc_ready=0, count=16. Extra alloc_req ignored. Retire one -> alloc_ready=1 the following cycle. Next alloc_tag=0 (wrap).
- Writeback to an unallocated tag 9 with wb_data=0xFFFF -> no done set; later allocation of tag 9 still waits for its own writeback.
- Flush with 5 entries pending plus a concurrent wb_valid -> count=0, head=tail=0, commit_valid=0. Next alloc_tag=0.
- With ROB_DUAL_WB_EN: wb tag2=0x11 and wb2 tag3=0x22 in the same cycle -> both retire on consecutive cycles. wb and wb2 to the same tag with 0x1/0x2 -> committed data 0x1.
